cpu_trace_buffer: RTL and testbench

Parametrised pipeline trace capture block for the CPU core, and the synthesizable successor to the cycle-by-cycle `$display` probing used on the full core. It samples one pipeline-state record per qualified cycle into a circular buffer of `DEPTH` entries. It stops after a programmable trigger plus `POST` further samples, then streams the frozen history out oldest-first over a valid/ready port. It sits beside the core, fed from fetch/decode/commit/writeback taps; both the core bench and an on-chip debug port read it.

---
 rtl/cpu_trace_pkg.sv | 25 ++
 rtl/cpu_trace_ram.sv | 35 +++
 rtl/cpu_trace_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types for the pipeline trace buffer: capture FSM states and the stored record.
package cpu_trace_pkg;

    localparam int unsigned TRACE_PC_W   = 32;
    localparam int unsigned TRACE_DATA_W = 32;
    localparam int unsigned TRACE_REG_AW = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [TRACE_PC_W-1:0]   pc;
        logic [TRACE_DATA_W-1:0] instr;
        logic [TRACE_DATA_W-1:0] alu;
        logic                    wb_en;
        logic [TRACE_REG_AW-1:0] wb_dest;
        logic                    stall;
        logic                    nop;
    } trace_rec_t;

endpackage

// File: rtl/cpu_trace_ram.sv
// Trace record storage: one write port, one registered read port.
module cpu_trace_ram
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  trace_rec_t        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output trace_rec_t        rd_data
);

    trace_rec_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset so the readout fields come up as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Pipeline trace capture: circular history, trigger plus post-trigger samples, then
// oldest-first readout over a valid/ready port.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned PC_W   = TRACE_PC_W,
    parameter int unsigned DATA_W = TRACE_DATA_W,
    parameter int unsigned REG_AW = TRACE_REG_AW,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned POST   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         force_trig,
    input  logic                         trig_pc_en,
    input  logic [PC_W-1:0]              trig_pc,
    input  logic                         trig_reg_en,
    input  logic [REG_AW-1:0]            trig_reg,
    input  logic                         filter_stall,
    input  logic [PC_W-1:0]              smp_pc,
    input  logic [DATA_W-1:0]            smp_instr,
    input  logic [DATA_W-1:0]            smp_alu,
    input  logic                         smp_wb_en,
    input  logic [REG_AW-1:0]            smp_wb_dest,
    input  logic                         smp_stall,
    input  logic                         smp_nop,
    output logic [1:0]                   state,
    output logic                         triggered,
    output logic [$clog2(DEPTH):0]       fill,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [PC_W-1:0]              rd_pc,
    output logic [DATA_W-1:0]            rd_instr,
    output logic [DATA_W-1:0]            rd_alu,
    output logic                         rd_wb_en,
    output logic [REG_AW-1:0]            rd_wb_dest,
    output logic                         rd_stall,
    output logic                         rd_nop,
    output logic                         rd_last
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    trace_state_t   state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic           trig_q, trig_d;
    logic           rd_valid_q, rd_valid_d;

    logic           capturing, in_done, qualified, hit, accept;
    logic [AW-1:0]  rd_addr;
    trace_rec_t     wr_rec, rd_rec;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (arm) state_d = StArmed;
            StArmed: begin
                if (arm) begin
                    state_d = StArmed;
                end else if (hit) begin
                    state_d = (POST == 0) ? StDone : StPost;
                end
            end
            StPost: begin
                if (arm) begin
                    state_d = StArmed;
                end else if (qualified && cnt_q == AW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone:  if (arm) state_d = StArmed;
            default: state_d = StIdle;
        endcase
    end

    // State decode; arm takes priority over sampling and readout in the same cycle
    always_comb begin
        capturing = (state_q == StArmed) || (state_q == StPost);
        in_done   = (state_q == StDone);
        qualified = capturing && !arm && !(filter_stall && smp_stall);
        hit       = qualified && (state_q == StArmed) &&
                    (force_trig ||
                     (trig_pc_en && smp_pc == trig_pc) ||
                     (trig_reg_en && smp_wb_en && smp_wb_dest == trig_reg));
        accept    = in_done && rd_valid_q && rd_ready && !arm;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        trig_d     = trig_q;
        rd_valid_d = rd_valid_q;
        if (arm) begin
            wr_ptr_d   = '0;
            cnt_d      = '0;
            fill_d     = '0;
            trig_d     = 1'b0;
            rd_valid_d = 1'b0;
        end else begin
            if (qualified) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != FW'(DEPTH)) begin
                    fill_d = fill_q + 1'b1;
                end
            end
            if (hit) begin
                trig_d = 1'b1;
                cnt_d  = AW'(POST);
            end else if (qualified && state_q == StPost) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (accept) begin
                fill_d     = fill_q - 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                rd_valid_d = (fill_q > FW'(1));
            end else if (in_done && !rd_valid_q && fill_q != '0) begin
                rd_valid_d = 1'b1;
            end
        end
        // Until readout starts, keep rd_ptr on the oldest held entry.
        if (!in_done) begin
            rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            fill_q     <= '0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            trig_q     <= trig_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        wr_rec.pc      = smp_pc;
        wr_rec.instr   = smp_instr;
        wr_rec.alu     = smp_alu;
        wr_rec.wb_en   = smp_wb_en;
        wr_rec.wb_dest = smp_wb_dest;
        wr_rec.stall   = smp_stall;
        wr_rec.nop     = smp_nop;
    end

    // Show-ahead: fetch the following entry in the same cycle the current one is taken.
    assign rd_addr = accept ? (rd_ptr_q + 1'b1) : rd_ptr_q;

    cpu_trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (qualified),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_rec),
        .rd_en   (in_done),
        .rd_addr (rd_addr),
        .rd_data (rd_rec)
    );

    assign state      = state_q;
    assign triggered  = trig_q;
    assign fill       = fill_q;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_valid_q && (fill_q == FW'(1));
    assign rd_pc      = rd_rec.pc;
    assign rd_instr   = rd_rec.instr;
    assign rd_alu     = rd_rec.alu;
    assign rd_wb_en   = rd_rec.wb_en;
    assign rd_wb_dest = rd_rec.wb_dest;
    assign rd_stall   = rd_rec.stall;
    assign rd_nop     = rd_rec.nop;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: queue-based history model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_cpu_trace_buffer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned POST_N = 3;

    logic        clock = 1'b0;
    logic        reset, arm, force_trig, trig_pc_en, trig_reg_en, filter_stall;
    logic [31:0] trig_pc, smp_pc, smp_instr, smp_alu;
    logic [4:0]  trig_reg, smp_wb_dest;
    logic        smp_wb_en, smp_stall, smp_nop, rd_ready;
    logic [1:0]  state;
    logic        triggered, rd_valid, rd_last, rd_wb_en, rd_stall, rd_nop;
    logic [3:0]  fill;
    logic [31:0] rd_pc, rd_instr, rd_alu;
    logic [4:0]  rd_wb_dest;

    always #5 clock = ~clock;

    cpu_trace_buffer #(
        .DEPTH (DEPTH),
        .POST  (POST_N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .arm          (arm),
        .force_trig   (force_trig),
        .trig_pc_en   (trig_pc_en),
        .trig_pc      (trig_pc),
        .trig_reg_en  (trig_reg_en),
        .trig_reg     (trig_reg),
        .filter_stall (filter_stall),
        .smp_pc       (smp_pc),
        .smp_instr    (smp_instr),
        .smp_alu      (smp_alu),
        .smp_wb_en    (smp_wb_en),
        .smp_wb_dest  (smp_wb_dest),
        .smp_stall    (smp_stall),
        .smp_nop      (smp_nop),
        .state        (state),
        .triggered    (triggered),
        .fill         (fill),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_pc        (rd_pc),
        .rd_instr     (rd_instr),
        .rd_alu       (rd_alu),
        .rd_wb_en     (rd_wb_en),
        .rd_wb_dest   (rd_wb_dest),
        .rd_stall     (rd_stall),
        .rd_nop       (rd_nop),
        .rd_last      (rd_last)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history is a queue capped at DEPTH, readout pops from its front.
    typedef struct {
        logic [31:0] pc, instr, alu;
        logic        wb_en;
        logic [4:0]  dest;
        logic        stall, nop;
    } mrec_t;

    mrec_t mq[$];
    int    m_state   = 0;
    int    m_left    = 0;
    bit    m_trig    = 0;
    bit    m_rd_valid = 0;
    bit    cmp_en    = 0;

    always @(posedge clock) begin : model
        mrec_t r;
        bit    hit;
        if (reset) begin
            m_state = 0; m_trig = 0; m_rd_valid = 0; m_left = 0; mq.delete();
        end else if (arm) begin
            m_state = 1; m_trig = 0; m_rd_valid = 0; m_left = 0; mq.delete();
        end else if (m_state == 1 || m_state == 2) begin
            if (!(filter_stall && smp_stall)) begin
                r.pc = smp_pc; r.instr = smp_instr; r.alu = smp_alu; r.wb_en = smp_wb_en;
                r.dest = smp_wb_dest; r.stall = smp_stall; r.nop = smp_nop;
                mq.push_back(r);
                if (mq.size() > DEPTH) void'(mq.pop_front());
                hit = force_trig || (trig_pc_en && smp_pc == trig_pc) ||
                      (trig_reg_en && smp_wb_en && smp_wb_dest == trig_reg);
                if (m_state == 1) begin
                    if (hit) begin
                        m_trig = 1;
                        m_left = POST_N;
                        m_state = (POST_N == 0) ? 3 : 2;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) m_state = 3;
                end
            end
        end else if (m_state == 3) begin
            if (m_rd_valid && rd_ready) void'(mq.pop_front());
            m_rd_valid = (mq.size() > 0);
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("state", state, 64'(m_state));
            check("triggered", triggered, m_trig);
            check("fill", fill, 64'(mq.size()));
            check("rd_valid", rd_valid, m_rd_valid);
            check("rd_last", rd_last, m_rd_valid && mq.size() == 1);
            if (m_rd_valid) begin
                check("rd_pc", rd_pc, mq[0].pc);
                check("rd_instr", rd_instr, mq[0].instr);
                check("rd_alu", rd_alu, mq[0].alu);
                check("rd_wb", {rd_wb_en, rd_wb_dest}, {mq[0].wb_en, mq[0].dest});
                check("rd_flags", {rd_stall, rd_nop}, {mq[0].stall, mq[0].nop});
            end
        end
    end

    logic [31:0] got_pc[$];
    bit          got_last[$];
    bit          got_stall[$];
    bit          got_wb[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        arm = 0; force_trig = 0; trig_pc_en = 0; trig_pc = 0; trig_reg_en = 0; trig_reg = 0;
        filter_stall = 0; smp_pc = 0; smp_instr = 0; smp_alu = 0; smp_wb_en = 0;
        smp_wb_dest = 0; smp_stall = 0; smp_nop = 0; rd_ready = 0;
    endtask

    task automatic rand_fields();
        smp_instr = $urandom; smp_alu = $urandom; smp_nop = 1'($urandom_range(0, 1));
        smp_stall = 1'($urandom_range(0, 1)); smp_wb_en = 1'($urandom_range(0, 1));
        smp_wb_dest = 5'($urandom_range(0, 31));
    endtask

    // Arm with a PC trigger and feed pc 0x00, 0x04, ... until DONE; returns last pc fed.
    task automatic capture_pcs(input logic [31:0] tpc, output logic [31:0] last_pc);
        logic [31:0] pc = 0;
        clear_inputs();
        trig_pc_en = 1; trig_pc = tpc; arm = 1;
        tick();
        arm = 0;
        last_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 64; i++) begin
            smp_pc = pc; rand_fields();
            last_pc = pc;
            pc += 4;
            tick();
            if (state == 2'd3) break;
        end
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0 repeating.
    task automatic readout(input int mode);
        got_pc.delete(); got_last.delete(); got_stall.delete(); got_wb.delete();
        for (int c = 0; c < 100; c++) begin
            rd_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            @(negedge clock);
            if (rd_valid && rd_ready) begin
                got_pc.push_back(rd_pc); got_last.push_back(rd_last);
                got_stall.push_back(rd_stall); got_wb.push_back(rd_wb_en);
            end
            if (got_pc.size() > 0 && !rd_valid) break;
            tick();
        end
        tick();
        rd_ready = 0;
    endtask

    initial begin
        logic [31:0] last_pc;
        int          n;
        int          k_done;

        clear_inputs();
        reset = 1;
        tick();
        cmp_en = 1;
        tick();
        reset = 0;
        check("rst_state", state, 2'd0);
        check("rst_fill", fill, 4'd0);
        check("rst_flags", {triggered, rd_valid, rd_last}, 3'b000);
        check("rst_fields", {rd_pc, rd_instr, rd_wb_dest}, '0);

        // PC trigger at 0x20, history wraps
        capture_pcs(32'h20, last_pc);
        check("t1_done_pc", last_pc, 32'h2C);
        check("t1_fill", fill, 4'd8);
        readout(0);
        check("t1_count", got_pc.size(), 8);
        for (int i = 0; i < got_pc.size() && i < 8; i++) begin
            check("t1_pc", got_pc[i], 32'h10 + 32'(4 * i));
            check("t1_last", got_last[i], i == 7);
        end
        check("t1_after", {state, rd_valid, fill}, {2'd3, 1'b0, 4'd0});

        // Trigger on the first sample
        capture_pcs(32'h00, last_pc);
        check("t2_done_pc", last_pc, 32'h0C);
        check("t2_fill", fill, 4'd4);
        readout(0);
        check("t2_count", got_pc.size(), 4);
        for (int i = 0; i < got_pc.size() && i < 4; i++) begin
            check("t2_pc", got_pc[i], 32'(4 * i));
        end

        // Stall filter with register trigger
        clear_inputs();
        trig_reg_en = 1; trig_reg = 5; filter_stall = 1; arm = 1;
        tick();
        arm = 0;
        k_done = -1;
        for (int k = 0; k < 40; k++) begin
            smp_pc = 32'(4 * k); smp_instr = $urandom; smp_alu = $urandom;
            smp_stall = 1'(k % 2);
            smp_wb_en = (k == 5 || k == 6);
            smp_wb_dest = (k == 5 || k == 6) ? 5'd5 : 5'd1;
            tick();
            if (k == 5) check("t3_stalled_no_trig", {state, triggered}, {2'd1, 1'b0});
            if (state == 2'd3) begin
                k_done = k;
                break;
            end
        end
        check("t3_done_k", 64'(k_done), 64'd12);
        check("t3_fill", fill, 4'd7);
        readout(0);
        check("t3_count", got_pc.size(), 7);
        for (int i = 0; i < got_pc.size() && i < 7; i++) begin
            check("t3_pc", got_pc[i], 32'(8 * i));
            check("t3_stall", got_stall[i], 1'b0);
            check("t3_wb", got_wb[i], i == 3);
        end

        // Backpressure
        capture_pcs(32'h20, last_pc);
        readout(1);
        check("t4_count", got_pc.size(), 8);
        for (int i = 0; i < got_pc.size() && i < 8; i++) begin
            check("t4_pc", got_pc[i], 32'h10 + 32'(4 * i));
        end
        check("t4_valid_after", rd_valid, 1'b0);

        // Reset in POST with counter at 2, then re-arm and force
        clear_inputs();
        arm = 1;
        tick();
        arm = 0; force_trig = 1; smp_pc = 32'h100;
        tick();
        force_trig = 0; smp_pc = 32'h104;
        check("t5_post", state, 2'd2);
        tick();
        reset = 1;
        tick();
        reset = 0;
        check("t5_reset", {state, fill, rd_valid}, {2'd0, 4'd0, 1'b0});
        arm = 1;
        tick();
        arm = 0; force_trig = 1; smp_pc = 32'h200;
        tick();
        force_trig = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            smp_pc = 32'h204 + 32'(4 * i);
            tick();
            n++;
            if (state == 2'd3) break;
        end
        check("t5_post_samples", 64'(n), 64'd3);
        check("t5_fill", fill, 4'd4);

        // Arm during readout at entry 3
        capture_pcs(32'h20, last_pc);
        rd_ready = 1;
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            @(negedge clock);
            if (rd_valid && rd_ready) n++;
            tick();
        end
        check("t6_entry3", rd_pc, 32'h1C);
        arm = 1;
        tick();
        arm = 0; rd_ready = 0;
        check("t6_rearm", {state, fill, rd_valid}, {2'd1, 4'd0, 1'b0});

        // Randomized traffic
        clear_inputs();
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 399) == 0);
            arm          = ($urandom_range(0, 39) == 0);
            force_trig   = ($urandom_range(0, 29) == 0);
            trig_pc_en   = 1'($urandom_range(0, 1));
            trig_pc      = 32'(4 * $urandom_range(0, 15));
            trig_reg_en  = 1'($urandom_range(0, 1));
            trig_reg     = 5'($urandom_range(0, 7));
            filter_stall = 1'($urandom_range(0, 1));
            rand_fields();
            smp_pc       = 32'(4 * $urandom_range(0, 15));
            smp_wb_dest  = 5'($urandom_range(0, 7));
            rd_ready     = 1'($urandom_range(0, 1));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
